mem_wb_stage: RTL and testbench

//  MEM->WB boundary of the 5-stage pipeline. Sits downstream of the data-memory stage.

---
 rtl/mem_wb_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM->WB pipeline boundary with dmem handshake, load alignment and timeout
//
// Purpose:
//   Holds the pipeline while a data-memory access is outstanding. Aligns and extends
//   load data. Registers the writeback bundle for WB.
//   Non-memory instructions pass straight through in one cycle.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   valid_m, instr_m, pc_m    live instruction in MEM, its encoding and PC
//   alu_result_m              ALU result, also the load/store address
//   memread_m, memwrite_m     instruction is a load / a store
//   regwrite_m, rd_addr_m     instruction writes rd, destination register
//   dmem_resp, dmem_rdata     access completes this cycle, word-aligned read data
//   stall_m                   combinational freeze of IF..MEM
//   valid_w .. rd_v_w         registered writeback bundle
//   mem_timeout               sticky flag: access waited TIMEOUT_CYCLES cycles

module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic [31:0] instr_m,
  input  logic [31:0] pc_m,
  input  logic [31:0] alu_result_m,
  input  logic        memread_m,
  input  logic        memwrite_m,
  input  logic        regwrite_m,
  input  logic [4:0]  rd_addr_m,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        stall_m,
  output logic        valid_w,
  output logic [31:0] instr_w,
  output logic [31:0] pc_w,
  output logic        regwrite_w,
  output logic [4:0]  rd_addr_w,
  output logic [31:0] rd_v_w,
  output logic        mem_timeout
);

  // The counter must be wide enough to reach TIMEOUT_CYCLES; keep at least one bit
  // so a disabled timeout still elaborates cleanly.
  localparam int CW = (TIMEOUT_CYCLES <= 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;

  logic            mem_op;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [1:0]      off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_data;
  logic [31:0]     wb_value;
  logic            wb_regwrite;

  assign opcode = instr_m[6:0];
  assign funct3 = instr_m[14:12];
  assign off    = alu_result_m[1:0];

  // A spurious dmem_resp without a memory op has no path into stall_m or the FSM.
  assign mem_op  = valid_m & (memread_m | memwrite_m);
  assign stall_m = mem_op & ~dmem_resp;

  // Lane selection from the word-aligned read data. Half accesses ignore off[0].
  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (off)
      2'd0: byte_sel = dmem_rdata[7:0];
      2'd1: byte_sel = dmem_rdata[15:8];
      2'd2: byte_sel = dmem_rdata[23:16];
      2'd3: byte_sel = dmem_rdata[31:24];
      default: byte_sel = dmem_rdata[7:0];
    endcase
    half_sel = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  end

  always_comb begin
    load_data = dmem_rdata;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {24'd0, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {16'd0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  // Writeback value select. Stores carry the address through, but never write rd.
  always_comb begin
    wb_value = alu_result_m;
    if (memread_m) begin
      wb_value = load_data;
    end else if (opcode == OP_JAL || opcode == OP_JALR) begin
      wb_value = pc_m + 32'd4;
    end
    wb_regwrite = valid_m & regwrite_m & ~memwrite_m;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      valid_w     <= 1'b0;
      instr_w     <= 32'd0;
      pc_w        <= 32'd0;
      regwrite_w  <= 1'b0;
      rd_addr_w   <= 5'd0;
      rd_v_w      <= 32'd0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (stall_m) begin
            state    <= S_WAIT;
            wait_cnt <= CW'(1);
          end
        end
        S_WAIT: begin
          if (mem_op && dmem_resp) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt != {CW{1'b1}}) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
          // The flag is informational only; the access keeps waiting.
          if ((TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_VAL)) begin
            mem_timeout <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
        end
      endcase

      if (stall_m) begin
        // Bubble: invalidate WB and hold the rest of the bundle.
        valid_w    <= 1'b0;
        regwrite_w <= 1'b0;
      end else begin
        valid_w    <= valid_m;
        instr_w    <= instr_m;
        pc_w       <= pc_m;
        regwrite_w <= wb_regwrite;
        rd_addr_w  <= rd_addr_m;
        rd_v_w     <= wb_value;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage

module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        valid_m;
  logic [31:0] instr_m;
  logic [31:0] pc_m;
  logic [31:0] alu_result_m;
  logic        memread_m;
  logic        memwrite_m;
  logic        regwrite_m;
  logic [4:0]  rd_addr_m;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        stall_m;
  logic        valid_w;
  logic [31:0] instr_w;
  logic [31:0] pc_w;
  logic        regwrite_w;
  logic [4:0]  rd_addr_w;
  logic [31:0] rd_v_w;
  logic        mem_timeout;

  int total;
  int bad;

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_m      (valid_m),
    .instr_m      (instr_m),
    .pc_m         (pc_m),
    .alu_result_m (alu_result_m),
    .memread_m    (memread_m),
    .memwrite_m   (memwrite_m),
    .regwrite_m   (regwrite_m),
    .rd_addr_m    (rd_addr_m),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .stall_m      (stall_m),
    .valid_w      (valid_w),
    .instr_w      (instr_w),
    .pc_w         (pc_w),
    .regwrite_w   (regwrite_w),
    .rd_addr_w    (rd_addr_w),
    .rd_v_w       (rd_v_w),
    .mem_timeout  (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] alu, input logic rd_en, input logic wr_en,
                        input logic rw, input logic [4:0] rd);
    valid_m      = v;
    instr_m      = ins;
    pc_m         = pc;
    alu_result_m = alu;
    memread_m    = rd_en;
    memwrite_m   = wr_en;
    regwrite_m   = rw;
    rd_addr_m    = rd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    set_op(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    dmem_resp  = 1'b0;
    dmem_rdata = 32'd0;
    step();
    step();
    check("rst_valid_w", {31'd0, valid_w}, 32'd0);
    check("rst_instr_w", instr_w, 32'd0);
    check("rst_pc_w", pc_w, 32'd0);
    check("rst_regwrite_w", {31'd0, regwrite_w}, 32'd0);
    check("rst_rd_addr_w", {27'd0, rd_addr_w}, 32'd0);
    check("rst_rd_v_w", rd_v_w, 32'd0);
    check("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    rst = 1'b0;

    // ADD x5: one-cycle pass-through
    set_op(1'b1, 32'h0000_02B3, 32'h0000_0100, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 5'd5);
    #1 check("add_stall", {31'd0, stall_m}, 32'd0);
    step();
    check("add_valid_w", {31'd0, valid_w}, 32'd1);
    check("add_rd_v_w", rd_v_w, 32'h0000_1234);
    check("add_rd_addr_w", {27'd0, rd_addr_w}, 32'd5);
    check("add_regwrite_w", {31'd0, regwrite_w}, 32'd1);
    check("add_pc_w", pc_w, 32'h0000_0100);
    check("add_instr_w", instr_w, 32'h0000_02B3);

    // LB, byte 3, same-cycle response
    set_op(1'b1, 32'h0000_0303, 32'h0000_0104, 32'h0000_1003, 1'b1, 1'b0, 1'b1, 5'd6);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h80FF_FF7F;
    #1 check("lb_stall", {31'd0, stall_m}, 32'd0);
    step();
    check("lb_rd_v_w", rd_v_w, 32'hFFFF_FF80);
    check("lb_valid_w", {31'd0, valid_w}, 32'd1);

    // LBU, same access
    set_op(1'b1, 32'h0000_4303, 32'h0000_0108, 32'h0000_1003, 1'b1, 1'b0, 1'b1, 5'd6);
    step();
    check("lbu_rd_v_w", rd_v_w, 32'h0000_0080);

    // LH off=2 with three wait cycles; rdata is junk until the response
    set_op(1'b1, 32'h0000_1383, 32'h0000_010C, 32'h0000_2002, 1'b1, 1'b0, 1'b1, 5'd7);
    dmem_resp  = 1'b0;
    dmem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("lh_stall_%0d", i), {31'd0, stall_m}, 32'd1);
      step();
      check($sformatf("lh_bubble_valid_%0d", i), {31'd0, valid_w}, 32'd0);
      check($sformatf("lh_bubble_rw_%0d", i), {31'd0, regwrite_w}, 32'd0);
      check($sformatf("lh_bubble_hold_%0d", i), rd_v_w, 32'h0000_0080);
    end
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h8001_0000;
    #1 check("lh_resp_stall", {31'd0, stall_m}, 32'd0);
    step();
    check("lh_rd_v_w", rd_v_w, 32'hFFFF_8001);
    check("lh_valid_w", {31'd0, valid_w}, 32'd1);
    check("lh_rd_addr_w", {27'd0, rd_addr_w}, 32'd7);
    check("lh_no_timeout", {31'd0, mem_timeout}, 32'd0);

    // LHU off=3: off[0] ignored, upper half zero-extended
    set_op(1'b1, 32'h0000_5383, 32'h0000_0110, 32'h0000_2003, 1'b1, 1'b0, 1'b1, 5'd7);
    step();
    check("lhu_rd_v_w", rd_v_w, 32'h0000_8001);

    // LH off=1: lower half sign-extended
    set_op(1'b1, 32'h0000_1383, 32'h0000_0114, 32'h0000_2001, 1'b1, 1'b0, 1'b1, 5'd7);
    dmem_rdata = 32'h1234_F00D;
    step();
    check("lh_off1_rd_v_w", rd_v_w, 32'hFFFF_F00D);

    // LW and an odd funct3 both return the full word
    set_op(1'b1, 32'h0000_2383, 32'h0000_0118, 32'h0000_2002, 1'b1, 1'b0, 1'b1, 5'd7);
    step();
    check("lw_rd_v_w", rd_v_w, 32'h1234_F00D);
    set_op(1'b1, 32'h0000_6383, 32'h0000_011C, 32'h0000_2001, 1'b1, 1'b0, 1'b1, 5'd7);
    step();
    check("f3_110_rd_v_w", rd_v_w, 32'h1234_F00D);

    // JAL at the top of the address space wraps to 0
    dmem_resp = 1'b0;
    set_op(1'b1, 32'h0000_00EF, 32'hFFFF_FFFC, 32'h0000_5555, 1'b0, 1'b0, 1'b1, 5'd1);
    step();
    check("jal_rd_v_w", rd_v_w, 32'h0000_0000);
    check("jal_regwrite_w", {31'd0, regwrite_w}, 32'd1);

    // JALR
    set_op(1'b1, 32'h0000_00E7, 32'h0000_0200, 32'h0000_5555, 1'b0, 1'b0, 1'b1, 5'd1);
    step();
    check("jalr_rd_v_w", rd_v_w, 32'h0000_0204);

    // Store: regwrite forced off, address carried in rd_v_w
    set_op(1'b1, 32'h0000_2023, 32'h0000_0204, 32'h0000_ABCD, 1'b0, 1'b1, 1'b1, 5'd9);
    dmem_resp = 1'b1;
    step();
    check("sw_valid_w", {31'd0, valid_w}, 32'd1);
    check("sw_regwrite_w", {31'd0, regwrite_w}, 32'd0);
    check("sw_rd_v_w", rd_v_w, 32'h0000_ABCD);

    // Spurious response with no live instruction
    set_op(1'b0, 32'h0000_0003, 32'h0000_0208, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 5'd3);
    dmem_resp = 1'b1;
    #1 check("spur_stall", {31'd0, stall_m}, 32'd0);
    step();
    check("spur_valid_w", {31'd0, valid_w}, 32'd0);
    check("spur_regwrite_w", {31'd0, regwrite_w}, 32'd0);

    // Timeout: load with no response, TIMEOUT_CYCLES=4
    set_op(1'b1, 32'h0000_2403, 32'h0000_0300, 32'h0000_4000, 1'b1, 1'b0, 1'b1, 5'd8);
    dmem_resp  = 1'b0;
    dmem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("to_clear_%0d", i), {31'd0, mem_timeout}, 32'd0);
    end
    step();
    check("to_set", {31'd0, mem_timeout}, 32'd1);
    check("to_still_stall", {31'd0, stall_m}, 32'd1);
    dmem_resp = 1'b1;
    step();
    check("to_sticky", {31'd0, mem_timeout}, 32'd1);
    check("to_load_done_valid", {31'd0, valid_w}, 32'd1);
    check("to_load_done_data", rd_v_w, 32'hCAFE_F00D);

    // Reset mid-WAIT drops the access and clears everything
    dmem_resp = 1'b0;
    step();
    check("rst_mid_wait_stall", {31'd0, stall_m}, 32'd1);
    rst = 1'b1;
    step();
    set_op(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    #1 check("rst2_stall", {31'd0, stall_m}, 32'd0);
    check("rst2_timeout", {31'd0, mem_timeout}, 32'd0);
    check("rst2_valid_w", {31'd0, valid_w}, 32'd0);
    check("rst2_rd_v_w", rd_v_w, 32'd0);
    check("rst2_pc_w", pc_w, 32'd0);
    check("rst2_instr_w", instr_w, 32'd0);
    check("rst2_rd_addr_w", {27'd0, rd_addr_w}, 32'd0);
    rst = 1'b0;

    // After reset a fresh ALU op passes through normally
    set_op(1'b1, 32'h0000_0533, 32'h0000_0400, 32'h0000_0042, 1'b0, 1'b0, 1'b1, 5'd10);
    step();
    check("post_rst_valid_w", {31'd0, valid_w}, 32'd1);
    check("post_rst_rd_v_w", rd_v_w, 32'h0000_0042);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
